flush_pump_pwm_gen: RTL and testbench
=====================================

FLUSH_PUMP_PWM_GEN -- requirements
Module: flush_pump_pwm_gen

Interface
REQ-001 SHALL have parameter MIN_PERIOD, default 2, meaning the smallest accepted period in clk cycles.
REQ-002 SHALL have parameter RAMP_STEP, default 1000, meaning the maximum duty increase per period in clk cycles (0 = ramp disabled).
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: pump run request from the PIO output register.
REQ-006 SHALL have port pwm_freq, input, 32 bits: requested period in clk cycles, driven by the flush pump PWM freq export.
REQ-007 SHALL have port pwm_duty, input, 32 bits: requested high time in clk cycles, driven by the flush pump PWM duty cycle export.
REQ-008 SHALL have port pwm_out, output, 1 bit: registered pump drive.
REQ-009 SHALL have port period_tick, output, 1 bit: one-cycle pulse at each period end.
REQ-010 SHALL have port running, output, 1 bit: high while in state RUN.
REQ-011 SHALL have port duty_eff, output, 32 bits: the duty currently applied.

Function
REQ-012 SHALL implement a state machine with two states, IDLE and RUN; all outputs SHALL be registered.
REQ-013 In IDLE: pwm_out=0, running=0, duty_eff=0, internal counter cnt=0.
REQ-014 IDLE->RUN SHALL occur when enable=1 and pwm_freq>=MIN_PERIOD; on that edge, latch per_sh=pwm_freq and tgt=min(pwm_duty,pwm_freq).
REQ-015 On the IDLE->RUN edge, duty_eff SHALL load min(tgt,RAMP_STEP), or tgt if RAMP_STEP=0.
REQ-016 In RUN: cnt SHALL increment each clk from 0 to per_sh-1 and then wrap to 0.
REQ-017 In RUN: pwm_out SHALL be high in the cycle after cnt<duty_eff holds, giving exactly duty_eff high cycles per per_sh-cycle period (1-cycle latency, first high cycle is the cycle after entering RUN).
REQ-018 duty_eff=0 SHALL give pwm_out constantly low; duty_eff>=per_sh SHALL give pwm_out constantly high with no glitch at wrap.
REQ-019 At wrap (cnt==per_sh-1): period_tick=1 for one cycle, and per_sh and tgt SHALL reload from the inputs using the REQ-014 rule; inputs changing mid-period SHALL have no effect until wrap.
REQ-020 At wrap, a ramp-up step (tgt>duty_eff) SHALL set duty_eff=min(duty_eff+RAMP_STEP,tgt), computed 33-bit with no overflow.
REQ-021 At wrap, a decrease (tgt<=duty_eff) SHALL set duty_eff=tgt immediately, and RAMP_STEP=0 SHALL set duty_eff=tgt.
REQ-022 At wrap, if pwm_freq<MIN_PERIOD, the block SHALL go to IDLE with REQ-013 values in the next cycle.
REQ-023 If enable=0 in any RUN cycle, the block SHALL go to IDLE in the next cycle (pwm_out=0, duty_eff=0, no period_tick), regardless of cnt.
REQ-024 If enable falls in the same cycle as a wrap, REQ-023 SHALL take precedence and period_tick SHALL stay 0.
REQ-025 Re-enable after IDLE SHALL restart the ramp from REQ-015; no duty history is kept.

Reset
REQ-026 reset_n=0 SHALL asynchronously force IDLE, cnt=0, per_sh=0, tgt=0, duty_eff=0, pwm_out=0, period_tick=0, running=0.
REQ-027 Reset deassertion SHALL be synchronised internally, and the first transition SHALL occur no earlier than the second clk edge after release.
REQ-028 Reset mid-period SHALL drop pwm_out within the same cycle.

Verification
REQ-029 Setting RAMP_STEP=0, freq=10, duty=3, enable=1 -> running next cycle; pwm_out is 3 high / 7 low, repeating; period_tick every 10 cycles.
REQ-030 Setting RAMP_STEP=2, freq=10, duty=7 -> duty_eff sequence 2,4,6,7,7 across successive periods, matching the pwm_out high counts.
REQ-031 Changing duty 3->8 at cnt=4 (RAMP_STEP=0) -> the current period keeps 3 high, and the next period has 8 high.
REQ-032 Running with duty=20, freq=10 -> pwm_out constantly high and duty_eff=10; running with duty=0 -> constantly low.
REQ-033 Setting freq=1 at runtime -> IDLE after the next wrap; dropping enable at cnt=5 -> pwm_out=0, running=0 the next cycle, no tick.
REQ-034 Asserting reset_n=0 while pwm_out=1 -> all outputs 0 immediately; after release with enable held, RUN restarts with duty_eff=min(tgt,RAMP_STEP).

Source files
------------

// File: rtl/flush_pump_pwm_gen.sv
// flush_pump_pwm_gen: flush pump PWM generator with per-period reload and soft-start duty ramp.
module flush_pump_pwm_gen #(
  parameter int unsigned MIN_PERIOD = 2,
  parameter int unsigned RAMP_STEP  = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] pwm_freq,
  input  logic [31:0] pwm_duty,
  output logic        pwm_out,
  output logic        period_tick,
  output logic        running,
  output logic [31:0] duty_eff
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, state_nx;
  logic [1:0]  rst_sync;
  logic [31:0] cnt, per_sh, tgt;
  logic [31:0] cnt_nx, per_nx, tgt_nx, duty_nx;
  logic        pwm_nx, tick_nx, run_nx;
  logic [31:0] req_tgt, ramp_init, ramp_up, duty_wrap;
  logic [32:0] ramp_sum;
  logic        freq_ok, wrap, ready;
  assign ready     = rst_sync[1];
  assign freq_ok   = pwm_freq >= 32'(MIN_PERIOD);
  assign req_tgt   = pwm_duty < pwm_freq ? pwm_duty : pwm_freq;
  assign ramp_init = (RAMP_STEP == 0 || req_tgt < 32'(RAMP_STEP)) ? req_tgt : 32'(RAMP_STEP);
  // 33-bit sum so a large duty plus step never wraps around
  assign ramp_sum  = {1'b0, duty_eff} + 33'(RAMP_STEP);
  assign ramp_up   = ramp_sum < {1'b0, req_tgt} ? ramp_sum[31:0] : req_tgt;
  assign duty_wrap = (RAMP_STEP == 0 || req_tgt <= duty_eff) ? req_tgt : ramp_up;
  assign wrap      = cnt == per_sh - 32'd1;
  // release of reset is seen by the FSM only after two clk edges
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      per_sh      <= '0;
      tgt         <= '0;
      duty_eff    <= '0;
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      per_sh      <= per_nx;
      tgt         <= tgt_nx;
      duty_eff    <= duty_nx;
      pwm_out     <= pwm_nx;
      period_tick <= tick_nx;
      running     <= run_nx;
    end
  always_comb
    state_nx = state == IDLE ? ((ready && enable && freq_ok) ? RUN : IDLE)
                             : ((!enable || (wrap && !freq_ok)) ? IDLE : RUN);
  always_comb begin
    cnt_nx  = '0;
    per_nx  = per_sh;
    tgt_nx  = tgt;
    duty_nx = '0;
    pwm_nx  = 1'b0;
    run_nx  = state_nx == RUN;
    tick_nx = state == RUN && enable && wrap;
    if (state == IDLE && state_nx == RUN) begin
      per_nx  = pwm_freq;
      tgt_nx  = req_tgt;
      duty_nx = ramp_init;
    end else if (state == RUN && state_nx == RUN) begin
      cnt_nx  = wrap ? '0 : cnt + 32'd1;
      pwm_nx  = cnt < duty_eff;
      per_nx  = wrap ? pwm_freq : per_sh;
      tgt_nx  = wrap ? req_tgt : tgt;
      duty_nx = wrap ? duty_wrap : duty_eff;
    end
  end
endmodule

// File: tb/tb_flush_pump_pwm_gen.sv
// tb_flush_pump_pwm_gen: directed table and sequence checks on two instances (RAMP_STEP 0 and 2).
module tb_flush_pump_pwm_gen;
  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic [31:0] pwm_freq = 32'd10, pwm_duty = 32'd3;
  logic        pwm0, tick0, run0, pwm2, tick2, run2;
  logic [31:0] de0, de2;
  int          checks = 0, errors = 0;

  typedef struct {
    logic        en;
    logic [31:0] f, d;
    logic        p0, t0, r;
    logic [31:0] d0;
    logic        p2;
    logic [31:0] d2;
  } vec_t;
  vec_t tbl[44];

  flush_pump_pwm_gen #(.MIN_PERIOD(2), .RAMP_STEP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_freq(pwm_freq), .pwm_duty(pwm_duty),
    .pwm_out(pwm0), .period_tick(tick0), .running(run0), .duty_eff(de0));
  flush_pump_pwm_gen #(.MIN_PERIOD(2), .RAMP_STEP(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_freq(pwm_freq), .pwm_duty(pwm_duty),
    .pwm_out(pwm2), .period_tick(tick2), .running(run2), .duty_eff(de2));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic wait_tick;
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step;
      seen = tick0;
    end
    chk("tick_seen", 32'(seen), 32'd1);
  endtask

  // expected applied duty in cycle R_j of the table run
  function automatic int d0f(input int j);
    return j < 30 ? 3 : 8;
  endfunction
  function automatic int d2f(input int j);
    return j < 10 ? 2 : j < 30 ? 3 : j < 40 ? 5 : 7;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      tbl[i].en = 1'b1; tbl[i].f = 32'd10; tbl[i].d = 32'd3;
      tbl[i].p0 = 1'b0; tbl[i].t0 = 1'b0; tbl[i].r = 1'b0; tbl[i].d0 = 32'd0;
      tbl[i].p2 = 1'b0; tbl[i].d2 = 32'd0;
    end
    for (int k = 0; k < 42; k++) begin
      tbl[k+2].en = 1'b1;
      tbl[k+2].f  = 32'd10;
      tbl[k+2].d  = k >= 25 ? 32'd8 : 32'd3;
      tbl[k+2].p0 = k > 0 && ((k - 1) % 10) < d0f(k - 1);
      tbl[k+2].t0 = k > 0 && (k % 10) == 0;
      tbl[k+2].r  = 1'b1;
      tbl[k+2].d0 = 32'(d0f(k));
      tbl[k+2].p2 = k > 0 && ((k - 1) % 10) < d2f(k - 1);
      tbl[k+2].d2 = 32'(d2f(k));
    end

    step;
    step;
    chk("rst_pwm", 32'(pwm0), 0);
    chk("rst_run", 32'(run0), 0);
    chk("rst_tick", 32'(tick0), 0);
    chk("rst_duty", de0, 0);
    enable  = 1'b1;
    reset_n = 1'b1;

    for (int i = 0; i < 44; i++) begin
      enable = tbl[i].en; pwm_freq = tbl[i].f; pwm_duty = tbl[i].d;
      step;
      chk($sformatf("v%0d_pwm0", i), 32'(pwm0), 32'(tbl[i].p0));
      chk($sformatf("v%0d_tick0", i), 32'(tick0), 32'(tbl[i].t0));
      chk($sformatf("v%0d_tick2", i), 32'(tick2), 32'(tbl[i].t0));
      chk($sformatf("v%0d_run0", i), 32'(run0), 32'(tbl[i].r));
      chk($sformatf("v%0d_run2", i), 32'(run2), 32'(tbl[i].r));
      chk($sformatf("v%0d_duty0", i), de0, tbl[i].d0);
      chk($sformatf("v%0d_pwm2", i), 32'(pwm2), 32'(tbl[i].p2));
      chk($sformatf("v%0d_duty2", i), de2, tbl[i].d2);
    end

    pwm_duty = 32'd20;
    wait_tick;
    chk("sat_duty0", de0, 32'd10);
    chk("sat_duty2", de2, 32'd9);
    for (int i = 0; i < 20; i++) begin
      step;
      chk($sformatf("sat_pwm0_%0d", i), 32'(pwm0), 32'd1);
    end
    chk("sat_duty2_end", de2, 32'd10);
    pwm_duty = 32'd0;
    wait_tick;
    chk("zero_duty0", de0, 32'd0);
    chk("zero_duty2", de2, 32'd0);
    for (int i = 0; i < 20; i++) begin
      step;
      chk($sformatf("zero_pwm0_%0d", i), 32'(pwm0), 32'd0);
      chk($sformatf("zero_pwm2_%0d", i), 32'(pwm2), 32'd0);
    end

    pwm_duty = 32'd8;
    wait_tick;
    chk("drop_pre_duty0", de0, 32'd8);
    for (int i = 0; i < 5; i++) step;
    chk("drop_pre_pwm0", 32'(pwm0), 32'd1);
    enable = 1'b0;
    step;
    chk("drop_run0", 32'(run0), 0);
    chk("drop_pwm0", 32'(pwm0), 0);
    chk("drop_tick0", 32'(tick0), 0);
    chk("drop_duty0", de0, 0);
    chk("drop_run2", 32'(run2), 0);

    enable = 1'b1;
    step;
    chk("restart_run0", 32'(run0), 1);
    chk("restart_duty0", de0, 32'd8);
    chk("restart_duty2", de2, 32'd2);
    for (int i = 0; i < 9; i++) step;
    chk("wrapdrop_pre_run0", 32'(run0), 1);
    enable = 1'b0;
    step;
    chk("wrapdrop_tick0", 32'(tick0), 0);
    chk("wrapdrop_tick2", 32'(tick2), 0);
    chk("wrapdrop_run0", 32'(run0), 0);

    enable = 1'b1;
    step;
    chk("short_start_run0", 32'(run0), 1);
    pwm_freq = 32'd1;
    for (int i = 0; i < 9; i++) step;
    chk("short_hold_run0", 32'(run0), 1);
    step;
    chk("short_idle_run0", 32'(run0), 0);
    chk("short_idle_duty0", de0, 0);
    chk("short_idle_pwm0", 32'(pwm0), 0);
    step;
    chk("short_stay_run0", 32'(run0), 0);

    pwm_freq = 32'd2;
    pwm_duty = 32'd1;
    step;
    chk("min_run0", 32'(run0), 1);
    chk("min_duty0", de0, 32'd1);
    chk("min_pwm0_r0", 32'(pwm0), 0);
    step;
    chk("min_pwm0_r1", 32'(pwm0), 1);
    step;
    chk("min_pwm0_r2", 32'(pwm0), 0);
    chk("min_tick0_r2", 32'(tick0), 1);
    step;
    chk("min_pwm0_r3", 32'(pwm0), 1);
    chk("min_pwm2_r3", 32'(pwm2), 1);

    #2 reset_n = 1'b0;
    #1;
    chk("arst_pwm0", 32'(pwm0), 0);
    chk("arst_pwm2", 32'(pwm2), 0);
    chk("arst_run0", 32'(run0), 0);
    chk("arst_tick0", 32'(tick0), 0);
    chk("arst_duty0", de0, 0);
    pwm_freq = 32'd10;
    pwm_duty = 32'd3;
    #2 reset_n = 1'b1;
    step;
    chk("rel_e1_run0", 32'(run0), 0);
    step;
    chk("rel_e2_run0", 32'(run0), 0);
    step;
    chk("rel_e3_run0", 32'(run0), 1);
    chk("rel_e3_duty0", de0, 32'd3);
    chk("rel_e3_duty2", de2, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
